// File: rtl/vga_scan_gen.sv
// vga_scan_gen: 640x480@60 VGA raster counters with a digit-field cell locator
module vga_scan_gen #(
    parameter int CLK_DIV  = 2,
    parameter int X_OFFSET = 0,
    parameter int Y_OFFSET = 0,
    parameter int SQUARE   = 20,
    parameter int DIGITS   = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic       in_field,
    output logic [2:0] digit_pos,
    output logic [1:0] cell_col,
    output logic [2:0] cell_row
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [15:0] HA  = 16'(H_ACTIVE);
    localparam logic [15:0] HS0 = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS1 = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VA  = 16'(V_ACTIVE);
    localparam logic [15:0] VS0 = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS1 = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] XS  = 16'(X_OFFSET);
    localparam logic [15:0] XE  = 16'(X_OFFSET + DIGITS * 3 * SQUARE);
    localparam logic [15:0] YS  = 16'(Y_OFFSET);
    localparam logic [15:0] YE  = 16'(Y_OFFSET + 5 * SQUARE);
    localparam logic [15:0] SQ1 = 16'(SQUARE - 1);

    logic [2:0]  div;
    logic        adv, x_wrap, y_wrap, nin_x, nin_y, in_x, in_y, x_cont, y_cont, px_last, ly_last;
    logic [9:0]  nx, ny, px, ly, px_n, ly_n;
    logic [15:0] nx16, ny16;
    logic [1:0]  cc, cc_n;
    logic [2:0]  dp, cr, dp_n, cr_n;

    // next raster position and next sub-counter values, applied on each pixel advance
    always_comb begin
        adv     = div == 3'(CLK_DIV - 1);
        x_wrap  = x == 10'(HT - 1);
        y_wrap  = y == 10'(VT - 1);
        nx      = x_wrap ? 10'd0 : x + 10'd1;
        ny      = x_wrap ? (y_wrap ? 10'd0 : y + 10'd1) : y;
        nx16    = {6'd0, nx};
        ny16    = {6'd0, ny};
        nin_x   = nx16 >= XS && nx16 < XE;
        nin_y   = ny16 >= YS && ny16 < YE;
        x_cont  = nin_x && in_x && !x_wrap;
        y_cont  = nin_y && in_y && !y_wrap;
        px_last = {6'd0, px} == SQ1;
        ly_last = {6'd0, ly} == SQ1;
        px_n    = x_cont ? (px_last ? 10'd0 : px + 10'd1) : 10'd0;
        cc_n    = x_cont ? (px_last ? (cc == 2'd2 ? 2'd0 : cc + 2'd1) : cc) : 2'd0;
        dp_n    = x_cont ? (px_last && cc == 2'd2 ? dp + 3'd1 : dp) : 3'd0;
        ly_n    = x_wrap ? (y_cont ? (ly_last ? 10'd0 : ly + 10'd1) : 10'd0) : ly;
        cr_n    = x_wrap ? (y_cont ? (ly_last ? cr + 3'd1 : cr) : 3'd0) : cr;
    end

    // pixel divider, raster counters and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            div         <= '0;
            pix_tick    <= 1'b0;
            x           <= '0;
            y           <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            active      <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            in_field    <= 1'b0;
            in_x        <= XS == 16'd0;
            in_y        <= YS == 16'd0;
            px          <= '0;
            cc          <= '0;
            dp          <= '0;
            ly          <= '0;
            cr          <= '0;
        end else begin
            div         <= adv ? 3'd0 : div + 3'd1;
            pix_tick    <= adv;
            frame_start <= adv && x_wrap && y_wrap;
            if (adv) begin
                x           <= nx;
                y           <= ny;
                hsync       <= !(nx16 >= HS0 && nx16 < HS1);
                vsync       <= !(ny16 >= VS0 && ny16 < VS1);
                active      <= nx16 < HA && ny16 < VA;
                in_field    <= nin_x && nin_y && nx16 < HA && ny16 < VA;
                frame_count <= frame_count + {7'd0, x_wrap && y_wrap};
                in_x        <= nin_x;
                in_y        <= nin_y;
                px          <= px_n;
                cc          <= cc_n;
                dp          <= dp_n;
                ly          <= ly_n;
                cr          <= cr_n;
            end
        end
    end

    assign digit_pos = in_field ? dp : 3'd0;
    assign cell_col  = in_field ? cc : 2'd0;
    assign cell_row  = in_field ? cr : 3'd0;
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: several parameterisations of vga_scan_gen against a cycle-count raster model
module tb_vga_scan_gen;
    localparam int NI = 5;
    localparam int P_DIV[NI] = '{2, 3, 1, 1, 1};
    localparam int P_XO[NI]  = '{0, 100, 100, 150, 0};
    localparam int P_YO[NI]  = '{0, 50, 10, 30, 0};
    localparam int P_SQ[NI]  = '{20, 20, 4, 4, 1};
    localparam int P_DG[NI]  = '{4, 4, 4, 4, 1};
    localparam int P_HA[NI]  = '{640, 640, 160, 160, 4};
    localparam int P_HF[NI]  = '{16, 16, 4, 4, 1};
    localparam int P_HS[NI]  = '{96, 96, 8, 8, 2};
    localparam int P_HB[NI]  = '{48, 48, 4, 4, 1};
    localparam int P_VA[NI]  = '{480, 480, 40, 40, 3};
    localparam int P_VF[NI]  = '{10, 10, 2, 2, 1};
    localparam int P_VS[NI]  = '{2, 2, 2, 2, 1};
    localparam int P_VB[NI]  = '{33, 33, 4, 4, 1};

    typedef struct packed {
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       act;
        logic       fs;
        logic [7:0] fc;
        logic       inf;
        logic [2:0] dp;
        logic [1:0] cc;
        logic [2:0] cr;
    } out_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_w[NI];
    logic [9:0] x_w[NI];
    logic [9:0] y_w[NI];
    logic       hs_w[NI];
    logic       vs_w[NI];
    logic       act_w[NI];
    logic       fs_w[NI];
    logic [7:0] fc_w[NI];
    logic       inf_w[NI];
    logic [2:0] dp_w[NI];
    logic [1:0] cc_w[NI];
    logic [2:0] cr_w[NI];
    int n = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) n <= reset ? 0 : n + 1;

    for (genvar g = 0; g < NI; g++) begin : u
        vga_scan_gen #(
            .CLK_DIV(P_DIV[g]), .X_OFFSET(P_XO[g]), .Y_OFFSET(P_YO[g]), .SQUARE(P_SQ[g]), .DIGITS(P_DG[g]),
            .H_ACTIVE(P_HA[g]), .H_FP(P_HF[g]), .H_SYNC(P_HS[g]), .H_BP(P_HB[g]),
            .V_ACTIVE(P_VA[g]), .V_FP(P_VF[g]), .V_SYNC(P_VS[g]), .V_BP(P_VB[g])
        ) dut (
            .clk(clk), .reset(reset), .pix_tick(tick_w[g]), .x(x_w[g]), .y(y_w[g]),
            .hsync(hs_w[g]), .vsync(vs_w[g]), .active(act_w[g]), .frame_start(fs_w[g]),
            .frame_count(fc_w[g]), .in_field(inf_w[g]), .digit_pos(dp_w[g]),
            .cell_col(cc_w[g]), .cell_row(cr_w[g])
        );
    end

    function automatic out_t obs(int i);
        out_t o;
        o.tick = tick_w[i]; o.x = x_w[i]; o.y = y_w[i]; o.hs = hs_w[i]; o.vs = vs_w[i];
        o.act = act_w[i]; o.fs = fs_w[i]; o.fc = fc_w[i]; o.inf = inf_w[i];
        o.dp = dp_w[i]; o.cc = cc_w[i]; o.cr = cr_w[i];
        return o;
    endfunction

    // expected outputs for instance i, k clocks after the last reset edge
    function automatic out_t model(int i, int k);
        out_t e;
        int ht, vt, p, xx, yy, fx, fy;
        bit started;
        ht = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
        vt = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
        p = k / P_DIV[i];
        xx = p % ht;
        yy = (p / ht) % vt;
        fx = xx - P_XO[i];
        fy = yy - P_YO[i];
        started = p > 0;
        e.tick = k > 0 && k % P_DIV[i] == 0;
        e.x = 10'(xx);
        e.y = 10'(yy);
        e.hs = !(started && xx >= P_HA[i] + P_HF[i] && xx < P_HA[i] + P_HF[i] + P_HS[i]);
        e.vs = !(started && yy >= P_VA[i] + P_VF[i] && yy < P_VA[i] + P_VF[i] + P_VS[i]);
        e.act = started && xx < P_HA[i] && yy < P_VA[i];
        e.fs = e.tick && xx == 0 && yy == 0;
        e.fc = 8'((p / (ht * vt)) % 256);
        e.inf = e.act && fx >= 0 && fx < P_DG[i] * 3 * P_SQ[i] && fy >= 0 && fy < 5 * P_SQ[i];
        e.dp = e.inf ? 3'(fx / (3 * P_SQ[i])) : 3'd0;
        e.cc = e.inf ? 2'((fx / P_SQ[i]) % 3) : 2'd0;
        e.cr = e.inf ? 3'(fy / P_SQ[i]) : 3'd0;
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            out_t o = obs(i);
            out_t e = model(i, 0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset inst%0d got %h expected %h", i, o, e);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_frame_wrap();
        int frames = 0;
        int c = 0;
        while (frames < 256 && c < 13000) begin
            @(negedge clk);
            c++;
            for (int i = 0; i < NI; i++) begin
                out_t o = obs(i);
                out_t e = model(i, n);
                checks++;
                if (o !== e) begin
                    errors++;
                    if (errors < 20) $display("FAIL run inst%0d n=%0d got %h expected %h", i, n, o, e);
                end
            end
            if (fs_w[4]) begin
                frames++;
                checks++;
                if (fc_w[4] !== 8'(frames % 256)) begin
                    errors++;
                    $display("FAIL frame_count frame %0d got %0d expected %0d", frames, fc_w[4], frames % 256);
                end
            end
        end
        checks++;
        if (frames != 256) begin
            errors++;
            $display("FAIL frame_wrap_timeout frames %0d expected 256", frames);
        end
    endtask

    task automatic test_sync_edges();
        logic [9:0] px = x_w[0];
        logic [9:0] py = y_w[2];
        logic ph = hs_w[0];
        logic pv = vs_w[2];
        bit fell = 0, rose = 0, vfell = 0;
        for (int c = 0; c < 10000 && !(fell && rose && vfell); c++) begin
            @(negedge clk);
            if (ph && !hs_w[0]) begin
                fell = 1;
                checks++;
                if ({px, x_w[0]} !== {10'd655, 10'd656}) begin
                    errors++;
                    $display("FAIL hsync_fall x %0d->%0d expected 655->656", px, x_w[0]);
                end
            end
            if (!ph && hs_w[0]) begin
                rose = 1;
                checks++;
                if ({px, x_w[0]} !== {10'd751, 10'd752}) begin
                    errors++;
                    $display("FAIL hsync_rise x %0d->%0d expected 751->752", px, x_w[0]);
                end
            end
            if (pv && !vs_w[2]) begin
                vfell = 1;
                checks++;
                if ({py, y_w[2]} !== {10'd41, 10'd42}) begin
                    errors++;
                    $display("FAIL vsync_fall y %0d->%0d expected 41->42", py, y_w[2]);
                end
            end
            px = x_w[0]; py = y_w[2]; ph = hs_w[0]; pv = vs_w[2];
        end
        checks++;
        if (!(fell && rose && vfell)) begin
            errors++;
            $display("FAIL sync_edge_timeout seen %0d%0d%0d expected 111", fell, rose, vfell);
        end
    endtask

    task automatic test_line_length();
        int first[3] = '{-1, -1, -1};
        int second[3] = '{-1, -1, -1};
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                if (tick_w[i] && x_w[i] == 10'd0) begin
                    if (first[i] < 0) first[i] = c;
                    else if (second[i] < 0) second[i] = c;
                end
        end
        for (int i = 0; i < 3; i++) begin
            int want = P_DIV[i] * (P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i]);
            checks++;
            if (second[i] < 0 || second[i] - first[i] != want) begin
                errors++;
                $display("FAIL line_length inst%0d got %0d expected %0d", i, second[i] - first[i], want);
            end
        end
    endtask

    task automatic test_mid_reset();
        repeat ($urandom_range(50, 700)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            out_t o = obs(i);
            checks++;
            if (o.x !== 10'd0 || o.y !== 10'd0 || o.hs !== 1'b1 || o.vs !== 1'b1 || o.fs !== 1'b0 || o.tick !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset inst%0d got x=%0d y=%0d hs=%b vs=%b fs=%b tick=%b expected 0 0 1 1 0 0",
                         i, o.x, o.y, o.hs, o.vs, o.fs, o.tick);
            end
        end
        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                out_t o = obs(i);
                out_t e = model(i, n);
                checks++;
                if (o !== e) begin
                    errors++;
                    if (errors < 20) $display("FAIL after_reset inst%0d n=%0d got %h expected %h", i, n, o, e);
                end
            end
        end
    endtask

    task automatic test_field();
        int ti[6] = '{2, 2, 2, 3, 3, 3};
        int tx[6] = '{104, 147, 148, 150, 159, 160};
        int ty[6] = '{14, 29, 29, 30, 35, 35};
        logic [8:0] tv[6] = '{9'b1_000_01_001, 9'b1_011_10_100, 9'b0, 9'b1_000_00_000, 9'b1_000_10_001, 9'b0};
        for (int k = 0; k < 6; k++) begin
            int i = ti[k];
            int c = 0;
            while (!(x_w[i] == 10'(tx[k]) && y_w[i] == 10'(ty[k])) && c < 9000) begin
                @(negedge clk);
                c++;
            end
            checks++;
            if ({inf_w[i], dp_w[i], cc_w[i], cr_w[i]} !== tv[k]) begin
                errors++;
                $display("FAIL field inst%0d (%0d,%0d) got %b expected %b", i, tx[k], ty[k],
                         {inf_w[i], dp_w[i], cc_w[i], cr_w[i]}, tv[k]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_frame_wrap();
        test_sync_edges();
        test_line_length();
        test_mid_reset();
        test_field();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
